// File: rtl/square_voice_core.sv
// Single-voice square oscillator with Q16 volume scaling and an optional one-pole low-pass bank.
// Define SQUARE_VOICE_FILTER_EN to build the filter bank; otherwise audio_out is the scaled sample >>> 6.
module square_voice_core #(
    parameter int WIDTH     = 32,
    parameter int AMP       = 1048576,
    parameter int N_FILTERS = 8
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    load,
    input  logic signed [WIDTH-1:0] load_sample,
    input  logic        [WIDTH-1:0] load_counter,
    input  logic        [WIDTH-1:0] wave_length,
    input  logic signed [WIDTH-1:0] volume,
    input  logic                    filter_en,
    input  logic        [2:0]       cutoff,
    output logic signed [WIDTH-1:0] sample_out,
    output logic        [WIDTH-1:0] counter_out,
    output logic signed [WIDTH-1:0] scaled_out,
    output logic signed [15:0]      audio_out
);

    localparam logic signed [WIDTH-1:0] AMP_POS     = WIDTH'(AMP);
    localparam logic signed [WIDTH-1:0] AMP_NEG     = -AMP_POS;
    localparam logic        [WIDTH-1:0] COUNTER_RST = WIDTH'(1);

    logic signed [WIDTH-1:0]   r_sample;
    logic        [WIDTH-1:0]   r_counter;
    logic signed [WIDTH-1:0]   r_scaled;

    logic signed [WIDTH-1:0]   w_base_sample;
    logic        [WIDTH-1:0]   w_base_counter;
    logic        [WIDTH-1:0]   w_half;
    logic        [WIDTH-1:0]   w_next_count;
    logic                      w_toggle;
    logic signed [WIDTH-1:0]   w_sample_next;
    logic        [WIDTH-1:0]   w_counter_next;
    logic signed [2*WIDTH-1:0] w_product;
    logic signed [WIDTH-1:0]   w_scaled_next;
    logic signed [15:0]        w_audio_raw;

    // A load replaces the state before advancing, so restore and step happen in the same edge.
    always_comb begin
        w_base_sample  = load ? load_sample  : r_sample;
        w_base_counter = load ? load_counter : r_counter;
        w_half         = wave_length >> 1;
        w_next_count   = w_base_counter + COUNTER_RST;
        w_toggle       = (w_next_count >= w_half);
        w_sample_next  = w_base_sample;
        w_counter_next = w_next_count;
        if (w_toggle) begin
            w_counter_next = '0;
            w_sample_next  = (w_base_sample < 0) ? AMP_POS : AMP_NEG;
        end
    end

    assign w_product = $signed({{WIDTH{r_sample[WIDTH-1]}}, r_sample})
                     * $signed({{WIDTH{volume[WIDTH-1]}}, volume});
    assign w_scaled_next = WIDTH'(w_product >>> 16);
    assign w_audio_raw   = 16'(r_scaled >>> 6);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sample  <= AMP_NEG;
            r_counter <= COUNTER_RST;
            r_scaled  <= '0;
        end else begin
            r_sample  <= w_sample_next;
            r_counter <= w_counter_next;
            r_scaled  <= w_scaled_next;
        end
    end

    assign sample_out  = r_sample;
    assign counter_out = r_counter;
    assign scaled_out  = r_scaled;

`ifdef SQUARE_VOICE_FILTER_EN
    logic signed [WIDTH-1:0] r_y      [N_FILTERS];
    logic signed [WIDTH-1:0] w_y_next [N_FILTERS];
    logic signed [WIDTH-1:0] w_x;
    logic signed [WIDTH-1:0] w_y_sel;

    assign w_x = r_scaled <<< 7;

    // Stage gi moves 1/2^gi of the remaining error per clock; stage 0 is a pure delay of x.
    for (genvar gi = 0; gi < N_FILTERS; gi++) begin : g_stage
        assign w_y_next[gi] = r_y[gi] + ((w_x - r_y[gi]) >>> gi);
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < N_FILTERS; k++) begin
            if (reset) begin
                r_y[k] <= '0;
            end else begin
                r_y[k] <= w_y_next[k];
            end
        end
    end

    // Out-of-range cutoff falls through to the slowest stage.
    always_comb begin
        w_y_sel = r_y[N_FILTERS-1];
        for (int k = 0; k < N_FILTERS; k++) begin
            if (int'(cutoff) == k) begin
                w_y_sel = r_y[k];
            end
        end
    end

    assign audio_out = filter_en ? 16'(w_y_sel >>> 16) : w_audio_raw;
`else
    logic w_unused_filter_cfg;
    assign w_unused_filter_cfg = ^{filter_en, cutoff};
    assign audio_out           = w_audio_raw;
`endif

endmodule

// File: tb/tb_square_voice_core.sv
// Randomized self-checking bench for square_voice_core against a behavioural model of the voice.
// Follows SQUARE_VOICE_FILTER_EN so the model matches the built configuration.
module tb_square_voice_core;

    localparam int AMP = 1048576;
    localparam int NF  = 8;

    logic               clk = 1'b0;
    logic               reset;
    logic               load;
    logic signed [31:0] load_sample;
    logic        [31:0] load_counter;
    logic        [31:0] wave_length;
    logic signed [31:0] volume;
    logic               filter_en;
    logic        [2:0]  cutoff;
    logic signed [31:0] sample_out;
    logic        [31:0] counter_out;
    logic signed [31:0] scaled_out;
    logic signed [15:0] audio_out;

    square_voice_core #(.WIDTH(32), .AMP(AMP), .N_FILTERS(NF)) dut (
        .clk(clk), .reset(reset), .load(load), .load_sample(load_sample),
        .load_counter(load_counter), .wave_length(wave_length), .volume(volume),
        .filter_en(filter_en), .cutoff(cutoff), .sample_out(sample_out),
        .counter_out(counter_out), .scaled_out(scaled_out), .audio_out(audio_out)
    );

    always #5 clk = ~clk;

    int          n_cmp = 0;
    int          n_bad = 0;
    logic        chk_en = 1'b0;

    int          m_sample;
    logic [31:0] m_counter;
    int          m_scaled;
    int          m_y [NF];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     name, $signed(act), act, $signed(exp), exp);
        end
    endtask

    // Model of the voice, expressed directly from the arithmetic rules.
    function automatic int base_s();
        return load ? int'(load_sample) : m_sample;
    endfunction

    function automatic logic [31:0] base_c();
        return load ? load_counter : m_counter;
    endfunction

    function automatic bit half_reached();
        logic [31:0] n;
        n = base_c() + 32'd1;
        return n >= (wave_length >> 1);
    endfunction

    function automatic int scale(input int s, input int v);
        longint p;
        p = longint'(s) * longint'(v);
        return int'(p >>> 16);
    endfunction

    function automatic logic signed [15:0] exp_audio();
        int t;
`ifdef SQUARE_VOICE_FILTER_EN
        int idx;
        if (filter_en) begin
            idx = (int'(cutoff) >= NF) ? NF - 1 : int'(cutoff);
            t = m_y[idx] >>> 16;
            return t[15:0];
        end
`endif
        t = m_scaled >>> 6;
        return t[15:0];
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_sample  <= -AMP;
            m_counter <= 32'd1;
            m_scaled  <= 0;
            for (int k = 0; k < NF; k++) m_y[k] <= 0;
        end else begin
            m_sample  <= half_reached() ? ((base_s() < 0) ? AMP : -AMP) : base_s();
            m_counter <= half_reached() ? 32'd0 : base_c() + 32'd1;
            m_scaled  <= scale(m_sample, int'(volume));
            for (int k = 0; k < NF; k++)
                m_y[k] <= m_y[k] + (((m_scaled <<< 7) - m_y[k]) >>> k);
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            check("sample_out",  sample_out,  m_sample);
            check("counter_out", counter_out, m_counter);
            check("scaled_out",  scaled_out,  m_scaled);
            check("audio_out",   32'(audio_out), 32'(exp_audio()));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check_reset_state(input string tag);
        check({tag, "_sample"},  sample_out,  -AMP);
        check({tag, "_counter"}, counter_out, 32'd1);
        check({tag, "_scaled"},  scaled_out,  32'd0);
        check({tag, "_audio"},   32'(audio_out), 32'd0);
    endtask

    initial begin
        reset = 1'b1; load = 1'b0; load_sample = '0; load_counter = '0;
        wave_length = 32'd8; volume = 32'sd65536; filter_en = 1'b0; cutoff = 3'd0;
        cyc(1);
        chk_en = 1'b1;
        check_reset_state("reset");
        $display("reset: sample=%0d counter=%0d", sample_out, counter_out);

        // Free-run, half period 4.
        reset = 1'b0;
        cyc(3);
        check("free_toggle_pos", sample_out, AMP);
        check("free_counter0", counter_out, 32'd0);
        cyc(1);
        check("free_audio_pos", 32'(audio_out), 32'(16384));
        cyc(3);
        check("free_toggle_neg", sample_out, -AMP);
        $display("free-run: sample=%0d audio=%0d", sample_out, audio_out);

        // Restore state through the load port.
        load = 1'b1; load_sample = AMP; load_counter = 32'd0; wave_length = 32'd100;
        cyc(1);
        load = 1'b0;
        check("load_sample", sample_out, AMP);
        check("load_counter", counter_out, 32'd1);
        volume = -32'sd65536;
        cyc(1);
        check("neg_vol_scaled", scaled_out, -AMP);
        check("neg_vol_audio", 32'(audio_out), -32'sd16384);
        wave_length = 32'd1;
        cyc(1);
        check("wl1_toggle_a", sample_out, -AMP);
        cyc(1);
        check("wl1_toggle_b", sample_out, AMP);
        $display("load/neg-volume/wl1: scaled=%0d sample=%0d", scaled_out, sample_out);

`ifdef SQUARE_VOICE_FILTER_EN
        // Negative volume on the reset sample holds scaled_out at +AMP from the first edge.
        reset = 1'b1; volume = -32'sd65536; wave_length = 32'd1000; filter_en = 1'b1; cutoff = 3'd1;
        cyc(1);
        reset = 1'b0;
        cyc(2);
        check("filt1_step0", 32'(audio_out), 32'(1024));
        cyc(1);
        check("filt1_step1", 32'(audio_out), 32'(1536));
        cyc(1);
        check("filt1_step2", 32'(audio_out), 32'(1792));
        cyc(1);
        check("filt1_step3", 32'(audio_out), 32'(1920));
        cutoff = 3'd0;
        #1;
        check("filt0_level", 32'(audio_out), 32'(2048));
        $display("filter: stage0 audio=%0d", audio_out);
`endif

        for (int i = 0; i < 3000; i++) begin
            if (i == 1500) begin
                reset = 1'b1;
                load = 1'b1; load_sample = AMP; load_counter = 32'd7;
                cyc(1);
                check_reset_state("midrun_reset");
                $display("mid-run reset: sample=%0d counter=%0d", sample_out, counter_out);
            end
            reset = ($urandom_range(0, 199) == 0);
            load = ($urandom_range(0, 7) == 0);
            case ($urandom_range(0, 3))
                0: load_sample = AMP;
                1: load_sample = -AMP;
                2: load_sample = 0;
                default: load_sample = $urandom;
            endcase
            load_counter = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : 32'($urandom_range(0, 63));
            if ($urandom_range(0, 9) == 0)
                wave_length = 32'($urandom_range(0, 1));
            else if ($urandom_range(0, 19) == 0)
                wave_length = $urandom;
            else
                wave_length = 32'($urandom_range(2, 40));
            case ($urandom_range(0, 3))
                0: volume = 32'sd65536;
                1: volume = -32'sd65536;
                2: volume = $signed(32'($urandom_range(0, 262143))) - 32'sd131072;
                default: volume = $urandom;
            endcase
            filter_en = 1'($urandom_range(0, 1));
            cutoff = 3'($urandom_range(0, 7));
            if (load)
                $display("load: sample=%0d counter=%0d wave_length=%0d", load_sample, load_counter, wave_length);
            cyc(1);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
